// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 87;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_pop_data;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_pop_data;

    // Full rejects a push even when a pop lands on the same edge.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pop_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_pop_data <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with upstream backpressure
import uart_pkg::*;

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data_in,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

    tx_state_t                 r_state;
    tx_state_t                 w_next_state;
    logic [BW-1:0]             r_baud;
    logic [IW-1:0]             r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;

    logic                      w_baud_last;
    logic                      w_pop;
    logic                      w_tx_next;
    logic                      w_full;
    logic                      w_empty;
    logic [UART_DATA_BITS-1:0] w_pop_data;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_data_valid),
        .i_push_data (i_data_in),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_baud_last  = (r_baud == BAUD_LAST);
    assign o_data_ready = !w_full;
    assign o_tx         = r_tx;
    assign o_busy       = (r_state != IDLE) || !w_empty;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_baud_last) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_last && (r_bit_idx == BIT_LAST)) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    // Popping on the last stop cycle keeps frames contiguous.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = START;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The FIFO read data is registered, so the shift register picks it up
    // when START hands over to DATA rather than on the pop edge itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_tx_next;

            if (r_state == IDLE || w_baud_last) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if (r_state == DATA) begin
                if (w_baud_last) begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end else begin
                r_bit_idx <= '0;
            end

            if (r_state == START && w_baud_last) begin
                r_shift <= w_pop_data;
            end else if (r_state == DATA && w_baud_last) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for the buffered UART transmitter
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data_in    (data),
        .i_data_valid (valid),
        .o_data_ready (ready),
        .o_tx         (tx),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [9:0] rx_frames[$];
    int         rx_start[$];

    // Line decoder: samples each bit mid-cell, bit k of a frame is sample k.
    logic       m_active = 1'b0;
    int         m_n = 0;
    int         m_start = 0;
    logic [9:0] m_bits = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (tx === 1'b0) begin
                m_active <= 1'b1;
                m_n      <= 1;
                m_start  <= cyc;
            end
        end else begin
            if ((m_n % CPB) == (CPB / 2)) begin
                m_bits[m_n / CPB] <= tx;
            end
            if (m_n == 9 * CPB + CPB / 2) begin
                rx_frames.push_back({tx, m_bits[8:0]});
                rx_start.push_back(m_start);
                m_active <= 1'b0;
            end
            m_n <= m_n + 1;
        end
    end

    function automatic logic [9:0] make_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, output logic acc);
        valid = v;
        data  = d;
        acc   = v && (ready === 1'b1);
        if (acc) exp_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_frames.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rx_frame_count", 32'(rx_frames.size() >= n), 32'd1);
    endtask

    task automatic check_frames(input int n);
        int         prev;
        int         st;
        logic [7:0] e;
        logic [9:0] f;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_frames.size() == 0 || exp_q.size() == 0) begin
                check("frame_available", 32'd0, 32'd1);
                break;
            end
            e  = exp_q.pop_front();
            f  = rx_frames.pop_front();
            st = rx_start.pop_front();
            check($sformatf("frame_%0d_byte_%02h", i, e), 32'(f), 32'(make_frame(e)));
            if (i > 0) check($sformatf("frame_%0d_gap", i), st - prev, FRAME);
            prev = st;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_idle", 32'(busy), 32'd0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   pc;
        int   s;
        int   accepts;
        int   first_low;
        int   k;
        int   glitches;

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(ready), 32'd1);
        end

        // Single byte: latency, bit pattern, frame length
        drive(1'b1, 8'hA5, acc);
        valid = 1'b0;
        check("push_a5", 32'(acc), 32'd1);
        pc = cyc;
        s  = pc + 2;
        while (cyc < s + FRAME - 2) @(negedge clk);
        check("busy_last_stop", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("tx_stop_tail", 32'(tx), 32'd1);
        wait_rx(1, 20);
        if (rx_start.size() > 0) check("start_latency", rx_start[0], s);
        check_frames(1);

        // Back-to-back 0x00 then 0xFF
        wait_idle();
        drive(1'b1, 8'h00, acc);
        drive(1'b1, 8'hFF, acc);
        valid = 1'b0;
        wait_rx(2, 3 * FRAME);
        check_frames(2);

        // Backpressure with bytes 1..6 held on the input
        wait_idle();
        accepts   = 0;
        first_low = -1;
        for (int b = 1; b <= 6; b++) begin
            k = 0;
            do begin
                drive(1'b1, 8'(b), acc);
                if (!acc && first_low < 0) first_low = accepts;
                k++;
            end while (!acc && k < 200);
            if (acc) accepts++;
        end
        valid = 1'b0;
        check("ready_drop_after", first_low, 32'd5);
        check("accepted_total", accepts, 32'd6);
        wait_rx(6, 8 * FRAME);
        check_frames(6);
        repeat (2 * FRAME) @(negedge clk);
        check("no_extra_frames", rx_frames.size(), 32'd0);

        // Push on the same edge as the STOP->START pop
        wait_idle();
        drive(1'b1, 8'h11, acc);
        pc = cyc;
        drive(1'b1, 8'h22, acc);
        valid = 1'b0;
        s = pc + 2;
        while (cyc < s + FRAME - 2) @(negedge clk);
        drive(1'b1, 8'h33, acc);
        check("push_with_pop", 32'(acc), 32'd1);
        drive(1'b1, 8'h44, acc);
        check("refill_44", 32'(acc), 32'd1);
        drive(1'b1, 8'h55, acc);
        check("refill_55", 32'(acc), 32'd1);
        drive(1'b1, 8'h66, acc);
        check("refill_66", 32'(acc), 32'd1);
        drive(1'b1, 8'h77, acc);
        check("full_rejects_77", 32'(acc), 32'd0);
        valid = 1'b0;
        wait_rx(6, 8 * FRAME);
        check_frames(6);

        // Reset during data bit 3 of 0x3C with two bytes queued
        wait_idle();
        drive(1'b1, 8'h3C, acc);
        pc = cyc;
        drive(1'b1, 8'h5A, acc);
        drive(1'b1, 8'h96, acc);
        valid = 1'b0;
        s = pc + 2;
        while (cyc < s + 4 * CPB + 1) @(negedge clk);
        check("bit3_of_3c", 32'(tx), 32'd1);
        check("busy_mid_frame", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        glitches = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) glitches++;
        end
        check("post_rst_quiet", glitches, 32'd0);
        check("post_rst_no_frames", rx_frames.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmit stage that sits directly downstream of `topVHDL`. It consumes the byte stream `topVHDL` produces on `data_out` with its `data_valid` strobe, buffers it in a small FIFO, and serialises each byte as an 8N1 frame on a single `tx` line. It gives the design a pin-level serial output, and backpressure is signalled upstream through `data_ready`.

## Interface
- `CLKS_PER_BIT`, default 87 — clock cycles per UART bit (10 MHz / 115200); legal values are ≥ 2.
- `FIFO_DEPTH`, default 4 — byte entries; must be a power of two, ≥ 2.
- `clk`  in  1  — single clock; every register is on its rising edge.
- `rst`  in  1  — synchronous reset, active-high.
- `data_in`  in  8  — byte from the upstream stage.
- `data_valid`  in  1  — `data_in` is valid this cycle.
- `data_ready`  out  1  — FIFO can accept a byte; equals `!full`.
- `tx`  out  1  — serial line, idles high; registered output.
- `busy`  out  1  — high while a frame is on the line or the FIFO is non-empty.

## Operation
- Push occurs when `data_valid && data_ready` at a clock edge. A byte offered while full is not accepted and is not captured later; upstream must hold it.
- `data_ready` is combinational from the FIFO count only. A push while full is rejected even if a pop happens in the same cycle.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into an 8-bit shift register, clear the baud counter and go to START. Otherwise stay.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = `shift[0]`, LSB first. After `CLKS_PER_BIT` cycles, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles. On its last cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- Baud counter runs 0 .. `CLKS_PER_BIT`-1 and wraps. A state transition occurs on the cycle it equals `CLKS_PER_BIT`-1.
- Bit index is 3 bits and wraps 7→0 on the DATA→STOP transition.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. The count is one bit wider, and full = (count == `FIFO_DEPTH`).
- Simultaneous push and pop when not full: both happen and the count is unchanged.
- `busy` = (state != IDLE) || (count != 0).

## Timing
- Reset values:
  - `tx` = 1, `busy` = 0, `data_ready` = 1.
  - State = IDLE, FIFO empty, counters = 0.
- Reset asserted mid-frame: the frame is abandoned and the FIFO is flushed. On the next edge `tx` = 1.
- Latency: the byte accepted at edge T into an empty FIFO while IDLE is popped at edge T+1. `tx` falls at edge T+2, the first start-bit cycle.
- A frame lasts exactly 10 × `CLKS_PER_BIT` cycles.
- Back-to-back frames are contiguous: the next start bit begins the cycle after the last stop-bit cycle.
- The slot freed by a pop makes `data_ready` rise in the cycle after the pop edge.

## Structure
- Package `uart_pkg` holds:
  - the state enum `tx_state_t` (IDLE, START, DATA, STOP);
  - constant `UART_DATA_BITS` = 8;
  - default `CLKS_PER_BIT` = 87.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): push/pop, `full`, `empty`, registered read data. It is reusable by the future receive path.
- The top of this block instantiates `sync_fifo` and contains the FSM, baud counter, bit index and shift register.

## Test plan
- Reset and idle: hold `rst` 3 cycles, release → `tx` = 1, `busy` = 0, `data_ready` = 1 for 50 cycles.
- Single byte: with `CLKS_PER_BIT` = 4, push 0xA5 → `tx` samples once per 4 cycles read 0,1,0,1,0,0,1,0,1,1. The first 0 appears 2 cycles after the push edge, the frame is 40 cycles, and `busy` falls after the stop bit.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - Frames are contiguous with no idle gap.
  - Bits read 0,00000000,1,0,11111111,1.
- Full/backpressure: with `FIFO_DEPTH` = 4, hold `data_valid` = 1 with bytes 0x01..0x06.
  - `data_ready` drops after 5 accepts: 1 popped into the shift register plus 4 in the FIFO.
  - All 6 bytes go out in order and none is lost or duplicated.
- Simultaneous push/pop: push on the same cycle as the STOP→START pop → count is unchanged and order is preserved.
- Reset mid-frame: assert `rst` during bit 3 of 0x3C with 2 bytes queued → `tx` = 1 next cycle, no further frames, `busy` = 0.
